mole_scheduler: RTL and testbench

//  Game sequencer for the whack-a-mole design: picks a pseudo-random mole, lights it
//  for a bounded window, judges button presses as hit/miss, keeps score and lives.

---
 rtl/mole_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer (LFSR mole pick, lit window, hit/miss scoring).
// Optional feature macro SCHED_SPEEDUP_EN: lit window shrinks after every hit down to a floor.
module mole_scheduler #(
  parameter int         N_MOLES   = 4,
  parameter int         WIN_CYC   = 1000,
  parameter int         GAP_CYC   = 200,
  parameter int         MAX_MISS  = 3,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               busy,
  output logic               game_over
);

  localparam int PW   = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  localparam int TMAX = (WIN_CYC > GAP_CYC) ? WIN_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]      GAP_LOAD  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]      WIN_INIT  = TW'(WIN_CYC);
  localparam logic [3:0]         MISS_LIM  = 4'(MAX_MISS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GAP    = 3'd1;
  localparam logic [2:0] ST_SPAWN  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [N_MOLES-1:0] onehot(input logic [PW-1:0] p);
    return {{(N_MOLES-1){1'b0}}, 1'b1} << p;
  endfunction

  logic [2:0]         state_r, state_s;
  logic [TW-1:0]      timer_r, timer_s;
  logic [N_MOLES-1:0] mole_r, mole_s;
  logic [N_MOLES-1:0] btn_q_r, press_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [3:0]         misses_r, misses_s;
  logic               hit_r, hit_s, miss_r, miss_s;
  logic               busy_r, over_r;
  logic [7:0]         lfsr_r;
  logic [PW-1:0]      prev_pos_r, prev_pos_s, raw_pos_s, spawn_pos_s;
  logic [TW-1:0]      win_len_s;

`ifdef SCHED_SPEEDUP_EN
  localparam logic [TW-1:0] WIN_STEP  = TW'(WIN_CYC >> 3);
  localparam logic [TW-1:0] WIN_FLOOR = TW'(WIN_CYC >> 2);
  logic [TW-1:0] win_len_r, win_len_nx_s;
  assign win_len_s = win_len_r;
`else
  assign win_len_s = WIN_INIT;
`endif

  assign press_s   = btn & ~btn_q_r;
  assign raw_pos_s = PW'(lfsr_r % 8'(N_MOLES));

  // Spawn position: never repeat the previous mole, step to the next one instead.
  always_comb begin
    if (raw_pos_s != prev_pos_r) begin
      spawn_pos_s = raw_pos_s;
    end else if (raw_pos_s == PW'(N_MOLES - 1)) begin
      spawn_pos_s = {PW{1'b0}};
    end else begin
      spawn_pos_s = raw_pos_s + PW'(1'b1);
    end
  end

  // Game FSM next-state and datapath updates.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    mole_s     = mole_r;
    score_s    = score_r;
    misses_s   = misses_r;
    prev_pos_s = prev_pos_r;
    hit_s      = 1'b0;
    miss_s     = 1'b0;
`ifdef SCHED_SPEEDUP_EN
    win_len_nx_s = win_len_r;
`endif
    case (state_r)
      ST_IDLE, ST_OVER: begin
        mole_s = {N_MOLES{1'b0}};
        if (start) begin
          score_s  = {SCORE_W{1'b0}};
          misses_s = 4'd0;
          timer_s  = GAP_LOAD;
          state_s  = ST_GAP;
`ifdef SCHED_SPEEDUP_EN
          win_len_nx_s = WIN_INIT;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_GAP: begin
        if (timer_r == {TW{1'b0}}) begin
          state_s = ST_SPAWN;
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      ST_SPAWN: begin
        mole_s     = onehot(spawn_pos_s);
        prev_pos_s = spawn_pos_s;
        timer_s    = win_len_s - TW'(1'b1);
        state_s    = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A lit press wins over the timeout, even on the final lit cycle.
        if (press_s[prev_pos_r]) begin
          hit_s   = 1'b1;
          mole_s  = {N_MOLES{1'b0}};
          timer_s = GAP_LOAD;
          state_s = ST_GAP;
          if (score_r != SCORE_MAX) begin
            score_s = score_r + SCORE_W'(1'b1);
          end else begin
            score_s = score_r;
          end
`ifdef SCHED_SPEEDUP_EN
          if (win_len_r >= WIN_FLOOR + WIN_STEP) begin
            win_len_nx_s = win_len_r - WIN_STEP;
          end else begin
            win_len_nx_s = WIN_FLOOR;
          end
`endif
        end else if (timer_r == {TW{1'b0}}) begin
          miss_s   = 1'b1;
          mole_s   = {N_MOLES{1'b0}};
          misses_s = misses_r + 4'd1;
          if (misses_s == MISS_LIM) begin
            state_s = ST_OVER;
          end else begin
            timer_s = GAP_LOAD;
            state_s = ST_GAP;
          end
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        mole_s  = {N_MOLES{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= {TW{1'b0}};
      mole_r     <= {N_MOLES{1'b0}};
      score_r    <= {SCORE_W{1'b0}};
      misses_r   <= 4'd0;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      busy_r     <= 1'b0;
      over_r     <= 1'b0;
      btn_q_r    <= {N_MOLES{1'b0}};
      lfsr_r     <= LFSR_SEED;
      prev_pos_r <= {PW{1'b0}};
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      mole_r     <= mole_s;
      score_r    <= score_s;
      misses_r   <= misses_s;
      hit_r      <= hit_s;
      miss_r     <= miss_s;
      busy_r     <= (state_s == ST_GAP) || (state_s == ST_SPAWN) || (state_s == ST_ACTIVE);
      over_r     <= (state_s == ST_OVER);
      btn_q_r    <= btn;
      lfsr_r     <= lfsr_next(lfsr_r);
      prev_pos_r <= prev_pos_s;
    end
  end

`ifdef SCHED_SPEEDUP_EN
  // Current lit-window length, shrunk on every hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_len_r <= WIN_INIT;
    end else begin
      win_len_r <= win_len_nx_s;
    end
  end
`endif

  assign mole       = mole_r;
  assign score      = score_r;
  assign misses     = misses_r;
  assign hit_pulse  = hit_r;
  assign miss_pulse = miss_r;
  assign busy       = busy_r;
  assign game_over  = over_r;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler (N_MOLES=4, WIN_CYC=64, GAP_CYC=8, SCORE_W=2).
module tb_mole_scheduler;

  localparam int N   = 4;
  localparam int WIN = 64;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [3:0] mole;
  logic [1:0] score;
  logic [3:0] misses;
  logic       hit_pulse, miss_pulse, busy, game_over;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;
  int exp_win = WIN;
  logic [1:0] exp_prev_pos = 2'd0;
  logic [7:0] tb_lfsr, tb_prev;
  logic [3:0] cur_oh;

  mole_scheduler #(
    .N_MOLES(N), .WIN_CYC(WIN), .GAP_CYC(GAP), .MAX_MISS(3), .SCORE_W(2), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .mole(mole), .score(score),
    .misses(misses), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .busy(busy),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR (x^8+x^6+x^5+x^4+1); tb_prev holds the value seen by the previous edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_lfsr <= 8'hA5;
      tb_prev <= 8'hA5;
    end else begin
      tb_prev <= tb_lfsr;
      tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end
  end

  task automatic predict(output logic [3:0] oh);
    logic [1:0] p;
    p = 2'(tb_prev % 8'd4);
    if (p == exp_prev_pos) p = p + 2'd1;
    exp_prev_pos = p;
    oh = 4'b0001 << p;
  endtask

  task automatic note_hit();
    exp_score = (exp_score < 3) ? exp_score + 1 : 3;
`ifdef SCHED_SPEEDUP_EN
    exp_win = (exp_win >= 24) ? exp_win - 8 : 16;
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_spawn(output int cyc);
    cyc = 0;
    while (mole === 4'd0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mole === 4'd0) begin
      errors++;
      $display("FAIL spawn_timeout: mole stayed %0h after %0d cycles, expected a lit mole", mole, cyc);
    end
  endtask

  task automatic count_lit(output int n);
    n = 1;
    while (n < 300) begin
      @(negedge clk);
      if (mole === 4'd0) break;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mole, score, misses, hit_pulse, miss_pulse, busy, game_over} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got mole=%0h score=%0h misses=%0h hit=%0b miss=%0b busy=%0b over=%0b, expected all 0",
               mole, score, misses, hit_pulse, miss_pulse, busy, game_over);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, game_over, mole} !== 6'd0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%0b over=%0b mole=%0h, expected 0 0 0", busy, game_over, mole);
    end
  endtask

  task automatic test_hit();
    logic [3:0] oh;
    int c;
    do_start();
    checks++;
    if (busy !== 1'b1 || score !== 2'd0) begin
      errors++;
      $display("FAIL start_busy: got busy=%0b score=%0d, expected 1 0", busy, score);
    end
    repeat (GAP) @(negedge clk);
    checks++;
    if (mole !== 4'd0) begin
      errors++;
      $display("FAIL gap_dark: got mole=%0h, expected 0", mole);
    end
    @(negedge clk);
    predict(oh);
    checks++;
    if (mole !== oh) begin
      errors++;
      $display("FAIL first_mole: got %0h, expected %0h", mole, oh);
    end
    cur_oh = oh;
    btn = oh;
    @(negedge clk);
    note_hit();
    checks++;
    if (hit_pulse !== 1'b1 || score !== 2'd1 || mole !== 4'd0 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit: got hit=%0b score=%0d mole=%0h miss=%0b, expected 1 1 0 0", hit_pulse, score, mole, miss_pulse);
    end
    btn = 4'd0;
    @(negedge clk);
    checks++;
    if (hit_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_cycle: got hit=%0b, expected 0", hit_pulse);
    end
    wait_spawn(c);
    predict(oh);
    checks++;
    if (c != GAP || mole !== oh || (mole & cur_oh) !== 4'd0) begin
      errors++;
      $display("FAIL second_mole: got mole=%0h after %0d, expected %0h after %0d, prev %0h", mole, c, oh, GAP, cur_oh);
    end
    cur_oh = oh;
  endtask

  task automatic test_wrong_late();
    btn = ~cur_oh;
    @(negedge clk);
    checks++;
    if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || mole !== cur_oh) begin
      errors++;
      $display("FAIL unlit_press: got hit=%0b miss=%0b mole=%0h, expected 0 0 %0h", hit_pulse, miss_pulse, mole, cur_oh);
    end
    btn = 4'd0;
    repeat (exp_win - 2) @(negedge clk);
    checks++;
    if (mole !== cur_oh) begin
      errors++;
      $display("FAIL last_lit_cycle: got mole=%0h, expected %0h", mole, cur_oh);
    end
    btn = cur_oh;
    @(negedge clk);
    note_hit();
    checks++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 2'd2 || mole !== 4'd0) begin
      errors++;
      $display("FAIL late_hit: got hit=%0b miss=%0b score=%0d mole=%0h, expected 1 0 2 0", hit_pulse, miss_pulse, score, mole);
    end
    btn = 4'd0;
    do_start();
    checks++;
    if (score !== 2'd2 || busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: got score=%0d busy=%0b over=%0b, expected 2 1 0", score, busy, game_over);
    end
  endtask

  task automatic test_game_over();
    logic [3:0] oh;
    int c, n;
    for (int i = 1; i <= 3; i++) begin
      wait_spawn(c);
      predict(oh);
      checks++;
      if (mole !== oh) begin
        errors++;
        $display("FAIL miss_mole_%0d: got %0h, expected %0h", i, mole, oh);
      end
      count_lit(n);
      checks++;
      if (n != exp_win || miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 4'(i)) begin
        errors++;
        $display("FAIL miss_%0d: got lit=%0d miss=%0b hit=%0b misses=%0d, expected %0d 1 0 %0d",
                 i, n, miss_pulse, hit_pulse, misses, exp_win, i);
      end
      checks++;
      if (busy !== (i < 3) || game_over !== (i == 3)) begin
        errors++;
        $display("FAIL over_flag_%0d: got busy=%0b over=%0b, expected %0b %0b", i, busy, game_over, i < 3, i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (miss_pulse !== 1'b0 || game_over !== 1'b1 || mole !== 4'd0) begin
      errors++;
      $display("FAIL over_hold: got miss=%0b over=%0b mole=%0h, expected 0 1 0", miss_pulse, game_over, mole);
    end
    do_start();
    exp_score = 0;
    exp_win = WIN;
    checks++;
    if (misses !== 4'd0 || score !== 2'd0 || busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: got misses=%0d score=%0d busy=%0b over=%0b, expected 0 0 1 0", misses, score, busy, game_over);
    end
  endtask

  task automatic test_score_window();
    logic [3:0] oh;
    int c;
    for (int i = 0; i < 8; i++) begin
      wait_spawn(c);
      predict(oh);
      checks++;
      if (mole !== oh) begin
        errors++;
        $display("FAIL win_mole_%0d: got %0h, expected %0h", i, mole, oh);
      end
      repeat (exp_win - 1) @(negedge clk);
      checks++;
      if (mole !== oh) begin
        errors++;
        $display("FAIL win_len_%0d: mole=%0h at lit cycle %0d, expected %0h", i, mole, exp_win, oh);
      end
      btn = (i % 2 == 1) ? 4'hF : oh;
      @(negedge clk);
      note_hit();
      checks++;
      if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 2'(exp_score) || mole !== 4'd0) begin
        errors++;
        $display("FAIL sat_hit_%0d: got hit=%0b miss=%0b score=%0d mole=%0h, expected 1 0 %0d 0",
                 i, hit_pulse, miss_pulse, score, mole, exp_score);
      end
      if (i < 7) btn = 4'd0;
    end
  endtask

  task automatic test_held_button();
    logic [3:0] oh;
    int c;
    wait_spawn(c);
    predict(oh);
    @(negedge clk);
    checks++;
    if (hit_pulse !== 1'b0 || mole !== oh) begin
      errors++;
      $display("FAIL held_no_hit: got hit=%0b mole=%0h, expected 0 %0h", hit_pulse, mole, oh);
    end
    btn = 4'd0;
    @(negedge clk);
    btn = oh;
    @(negedge clk);
    note_hit();
    checks++;
    if (hit_pulse !== 1'b1 || score !== 2'd3) begin
      errors++;
      $display("FAIL repress_hit: got hit=%0b score=%0d, expected 1 3", hit_pulse, score);
    end
    btn = 4'd0;
  endtask

  task automatic test_timeout();
    logic [3:0] oh;
    int c, n;
    wait_spawn(c);
    predict(oh);
    count_lit(n);
    checks++;
    if (n != exp_win || miss_pulse !== 1'b1 || misses !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got lit=%0d miss=%0b misses=%0d busy=%0b, expected %0d 1 1 1", n, miss_pulse, misses, busy, exp_win);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    wait_spawn(c);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mole, score, misses, hit_pulse, miss_pulse, busy, game_over} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got mole=%0h score=%0d misses=%0d hit=%0b miss=%0b busy=%0b over=%0b, expected all 0",
               mole, score, misses, hit_pulse, miss_pulse, busy, game_over);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_prev_pos = 2'd0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mole !== 4'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%0b mole=%0h over=%0b, expected 0 0 0", busy, mole, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_wrong_late();
    test_game_over();
    test_score_window();
    test_held_button();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
